// File: rtl/falling_object_spawner.sv
// Spawn scheduler for a pool of falling-object datapaths: per-slot FREE/LOAD/ARM/ACTIVE FSM, LFSR spawn X, common speed.
// Optional speed-up per level is enabled by defining SPAWNER_SPEEDUP_EN.
module falling_object_spawner #(
  parameter int unsigned NUM_SLOTS           = 4,
  parameter int unsigned SPAWN_PERIOD_FRAMES = 60,
  parameter int unsigned X_MIN               = 0,
  parameter int unsigned X_MAX               = 607,
  parameter int unsigned BASE_SPEED          = 64,
  parameter int unsigned SPEED_STEP          = 16,
  parameter int unsigned SPAWNS_PER_LEVEL    = 8,
  parameter int unsigned MAX_SPEED           = 256,
  parameter logic [15:0] LFSR_SEED           = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   startOfFrame,
  input  logic                   enable,
  input  logic [NUM_SLOTS-1:0]   exceed,
  input  logic [NUM_SLOTS-1:0]   hit,
  output logic [NUM_SLOTS-1:0]   load,
  output logic [NUM_SLOTS-1:0]   visible,
  output logic signed [10:0]     topLeftXRand,
  output logic signed [31:0]     speed,
  output logic [3:0]             activeCount
);

  typedef enum logic [1:0] {FREE, LOAD, ARM, ACTIVE} slot_state_t;

  localparam int unsigned FW       = $clog2(SPAWN_PERIOD_FRAMES + 1);
  localparam logic [FW:0] PERIOD_V = (FW+1)'(SPAWN_PERIOD_FRAMES);
  localparam logic [10:0] RANGE_V  = 11'(X_MAX - X_MIN + 1);

  slot_state_t            state     [NUM_SLOTS];
  slot_state_t            stateNext [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]   eligible, retire, sel, cool;
  logic                   found, spawnGo, periodHit, pending;
  logic [FW-1:0]          frameCnt;
  logic [FW:0]            frameInc;
  logic [15:0]            spawnCnt;
  logic [15:0]            lfsr, lfsrNext;
  logic [10:0]            rVal, offVal, xNew, xReg;
  logic [31:0]            speedReg;

  // State register
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (!resetN) state[i] <= FREE;
      else         state[i] <= stateNext[i];
    end
  end

  // A slot retired this frame stays ineligible until the next startOfFrame;
  // that startOfFrame cycle itself already counts as eligible.
  always_comb begin
    eligible = '0;
    retire   = '0;
    sel      = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      eligible[i] = (state[i] == FREE) && (!cool[i] || startOfFrame);
      retire[i]   = (state[i] == ACTIVE) && (exceed[i] || hit[i]);
      if (eligible[i] && !found) begin
        sel[i] = 1'b1;
        found  = 1'b1;
      end
    end
    spawnGo = pending && enable && found;
  end

  // Next-state logic
  always_comb begin
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      stateNext[i] = state[i];
      case (state[i])
        FREE:    if (spawnGo && sel[i]) stateNext[i] = LOAD;
        LOAD:    stateNext[i] = ARM;
        ARM:     stateNext[i] = ACTIVE;
        ACTIVE:  if (retire[i]) stateNext[i] = FREE;
        default: stateNext[i] = FREE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    load        = '0;
    visible     = '0;
    activeCount = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      load[i]     = (state[i] == LOAD);
      visible[i]  = (state[i] == ACTIVE);
      activeCount = activeCount + {3'b000, visible[i]};
    end
  end

  // Period fires on the startOfFrame that brings the count up to SPAWN_PERIOD_FRAMES
  always_comb begin
    frameInc  = {1'b0, frameCnt} + (FW+1)'(1);
    periodHit = startOfFrame && enable && (frameInc >= PERIOD_V);
  end

  always_comb begin
    lfsrNext = {1'b0, lfsr[15:1]};
    if (lfsr[0]) lfsrNext = lfsrNext ^ 16'hB400;
    rVal   = {1'b0, lfsr[9:0]};
    offVal = (rVal >= RANGE_V) ? (rVal - RANGE_V) : rVal;
    xNew   = 11'(X_MIN) + offVal;
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      frameCnt <= '0;
      pending  <= 1'b0;
      spawnCnt <= '0;
      cool     <= '0;
      lfsr     <= LFSR_SEED;
      xReg     <= 11'(X_MIN);
    end else begin
      lfsr <= lfsrNext;
      cool <= (cool & ~{NUM_SLOTS{startOfFrame}}) | retire;
      if (startOfFrame && enable)
        frameCnt <= periodHit ? '0 : frameInc[FW-1:0];
      if (periodHit)    pending <= 1'b1;
      else if (spawnGo) pending <= 1'b0;
      if (spawnGo) begin
        xReg     <= xNew;
        spawnCnt <= spawnCnt + 16'd1;
      end
    end
  end

`ifdef SPAWNER_SPEEDUP_EN
  logic [15:0] lvlCnt;
  logic        levelTick;
  logic [31:0] speedSum;

  assign speedSum = speedReg + 32'(SPEED_STEP);

  // levelTick is high during the load cycle, so speed changes one cycle later
  always_ff @(posedge clk) begin
    if (!resetN) begin
      lvlCnt    <= '0;
      levelTick <= 1'b0;
      speedReg  <= 32'(BASE_SPEED);
    end else begin
      levelTick <= 1'b0;
      if (spawnGo) begin
        if (lvlCnt == 16'(SPAWNS_PER_LEVEL - 1)) begin
          lvlCnt    <= '0;
          levelTick <= 1'b1;
        end else begin
          lvlCnt <= lvlCnt + 16'd1;
        end
      end
      if (levelTick)
        speedReg <= (speedSum >= 32'(MAX_SPEED)) ? 32'(MAX_SPEED) : speedSum;
    end
  end
`else
  assign speedReg = 32'(BASE_SPEED);
`endif

  assign topLeftXRand = signed'(xReg);
  assign speed        = signed'(speedReg);

endmodule

// File: tb/tb_falling_object_spawner.sv
// Directed, table-driven bench for falling_object_spawner (4 slots, 2-frame period, 2 spawns per level).
module tb_falling_object_spawner;

  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        startOfFrame = 1'b0;
  logic        enable = 1'b0;
  logic [3:0]  exceed = '0;
  logic [3:0]  hit = '0;
  logic [3:0]  load, visible, activeCount;
  logic signed [10:0] topLeftXRand;
  logic signed [31:0] speed;

  int nchecks = 0;
  int nerrors = 0;

  falling_object_spawner #(
    .NUM_SLOTS(4),
    .SPAWN_PERIOD_FRAMES(2),
    .X_MIN(0),
    .X_MAX(607),
    .BASE_SPEED(64),
    .SPEED_STEP(16),
    .SPAWNS_PER_LEVEL(2),
    .MAX_SPEED(256),
    .LFSR_SEED(SEED)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .startOfFrame(startOfFrame),
    .enable(enable),
    .exceed(exceed),
    .hit(hit),
    .load(load),
    .visible(visible),
    .topLeftXRand(topLeftXRand),
    .speed(speed),
    .activeCount(activeCount)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic [15:0] n;
    n = {1'b0, v[15:1]};
    if (v[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  function automatic logic [10:0] x_of(input logic [15:0] v);
    logic [10:0] r;
    r = {1'b0, v[9:0]};
    return (r >= 11'd608) ? r - 11'd608 : r;
  endfunction

  // Reference LFSR; mprev is the value the DUT used at the most recent edge
  logic [15:0] mlfsr = SEED, mprev = SEED;
  always @(posedge clk) begin
    if (!resetN) mlfsr <= SEED;
    else         mlfsr <= lfsr_step(mlfsr);
    mprev <= mlfsr;
  end

  typedef struct {
    logic       sof;
    logic       en;
    logic [3:0] exc;
    logic [3:0] hitv;
    logic [3:0] eload;
    logic [3:0] evis;
    logic [3:0] eact;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic s, input logic e, input logic [3:0] x, input logic [3:0] h,
                     input logic [3:0] l, input logic [3:0] v, input logic [3:0] a);
    vec_t t;
    t.sof = s; t.en = e; t.exc = x; t.hitv = h; t.eload = l; t.evis = v; t.eact = a;
    vecs.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " load"}, 32'(load), 32'h0);
    chk({tag, " visible"}, 32'(visible), 32'h0);
    chk({tag, " activeCount"}, 32'(activeCount), 32'h0);
    chk({tag, " speed"}, speed, 32'd64);
    chk({tag, " x"}, 32'(topLeftXRand), 32'h0);
  endtask

  initial begin
    int spawnN;
    int cyc;
    logic [31:0] expSpeed;

    // Rows: sof, en, exceed, hit | expected load, visible, activeCount after the edge
    add(0,1,0,0, 0,4'h0,0); add(1,1,0,0, 0,4'h0,0); add(0,1,0,0, 0,4'h0,0); add(1,1,0,0, 0,4'h0,0);
    add(0,1,0,0, 4'h1,4'h0,0); add(0,1,0,0, 0,4'h0,0); add(0,1,0,0, 0,4'h1,1);
    add(1,1,0,0, 0,4'h1,1); add(0,1,0,0, 0,4'h1,1); add(1,1,0,0, 0,4'h1,1);
    add(0,1,0,0, 4'h2,4'h1,1); add(0,1,0,0, 0,4'h1,1); add(0,1,0,0, 0,4'h3,2);
    add(1,1,0,0, 0,4'h3,2); add(0,1,0,0, 0,4'h3,2); add(1,1,0,0, 0,4'h3,2);
    add(0,1,0,0, 4'h4,4'h3,2); add(0,1,0,0, 0,4'h3,2); add(0,1,0,0, 0,4'h7,3);
    add(1,1,0,0, 0,4'h7,3); add(0,1,0,0, 0,4'h7,3); add(1,1,0,0, 0,4'h7,3);
    add(0,1,0,0, 4'h8,4'h7,3); add(0,1,0,0, 0,4'h7,3); add(0,1,0,0, 0,4'hF,4);
    // exceed[2] retires slot 2, the next spawn reuses it
    add(0,1,4'h4,0, 0,4'hB,3); add(1,1,0,0, 0,4'hB,3); add(0,1,0,0, 0,4'hB,3); add(1,1,0,0, 0,4'hB,3);
    add(0,1,0,0, 4'h4,4'hB,3); add(0,1,0,0, 0,4'hB,3); add(0,1,0,0, 0,4'hF,4);
    // Three periods while full, then hit[1] just before a frame
    add(1,1,0,0, 0,4'hF,4); add(0,1,0,0, 0,4'hF,4); add(1,1,0,0, 0,4'hF,4); add(0,1,0,0, 0,4'hF,4);
    add(1,1,0,0, 0,4'hF,4); add(0,1,0,0, 0,4'hF,4); add(1,1,0,0, 0,4'hF,4);
    add(1,1,0,0, 0,4'hF,4); add(0,1,0,0, 0,4'hF,4); add(1,1,0,0, 0,4'hF,4);
    add(0,1,0,4'h2, 0,4'hD,3); add(1,1,0,0, 4'h2,4'hD,3); add(0,1,0,0, 0,4'hD,3); add(0,1,0,0, 0,4'hF,4);
    // Only one spawn came out of the three periods
    add(1,0,0,4'h1, 0,4'hE,3); add(1,0,0,0, 0,4'hE,3); add(0,1,0,0, 0,4'hE,3); add(0,1,0,0, 0,4'hE,3);
    // enable=0 for 5 frames holds frameCnt at 1
    for (int k = 0; k < 5; k++) begin
      add(1,0,0,0, 0,4'hE,3); add(0,0,0,0, 0,4'hE,3);
    end
    add(1,1,0,0, 0,4'hE,3); add(0,1,0,0, 4'h1,4'hE,3); add(0,1,0,0, 0,4'hE,3); add(0,1,0,0, 0,4'hF,4);

    @(negedge clk);
    resetN = 1'b0; enable = 1'b1;
    repeat (3) step();
    chk_reset("reset");

    resetN = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      startOfFrame = vecs[i].sof; enable = vecs[i].en;
      exceed = vecs[i].exc; hit = vecs[i].hitv;
      step();
      chk($sformatf("vec%0d load", i), 32'(load), 32'(vecs[i].eload));
      chk($sformatf("vec%0d visible", i), 32'(visible), 32'(vecs[i].evis));
      chk($sformatf("vec%0d activeCount", i), 32'(activeCount), 32'(vecs[i].eact));
    end

    // Reset arriving while slot 3 is in LOAD
    startOfFrame = 1'b0; enable = 1'b1; exceed = '0; hit = 4'h8;
    step();
    hit = '0; startOfFrame = 1'b1;
    step();
    step();
    startOfFrame = 1'b0;
    step();
    chk("pre-reset load", 32'(load), 32'h8);
    resetN = 1'b0;
    step();
    chk_reset("mid-reset");
    step();
    resetN = 1'b1;

    // 1000 spawns: every visible slot is destroyed at once, X and speed checked at each load
    spawnN = 0;
    cyc = 0;
    while (spawnN < 1000 && cyc < 30000) begin
      if (load != 4'h0) begin
        spawnN++;
        chk($sformatf("spawn%0d onehot", spawnN), 32'($countones(load)), 32'd1);
        chk($sformatf("spawn%0d x", spawnN), 32'(topLeftXRand), 32'(x_of(mprev)));
        chk($sformatf("spawn%0d x<=607", spawnN), 32'(topLeftXRand <= 11'sd607 && topLeftXRand >= 11'sd0), 32'd1);
`ifdef SPAWNER_SPEEDUP_EN
        expSpeed = 32'(64 + 16 * ((spawnN - 1) / 2));
        if (expSpeed > 32'd256) expSpeed = 32'd256;
`else
        expSpeed = 32'd64;
`endif
        chk($sformatf("spawn%0d speed", spawnN), speed, expSpeed);
      end
      hit = visible;
      startOfFrame = (cyc % 4 == 0);
      step();
      cyc++;
    end
    chk("spawn count within budget", 32'(spawnN), 32'd1000);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
